// File: rtl/cpu_param_if.sv
// ROM fetch bus and board I/O for the parametrised teaching CPU.
// The core uses the master side. A ROM/board model or a bench uses the slave side.
interface cpu_param_if #(
  parameter int unsigned DW  = 4,
  parameter int unsigned PCW = 5
);
  logic [PCW-1:0] pc;
  logic [15:0]    instr;
  logic [DW-1:0]  btn;
  logic [DW-1:0]  led;
  logic           halted;
  logic           stack_err;

  modport master (
    output pc, led, halted, stack_err,
    input  instr, btn
  );

  modport slave (
    input  pc, led, halted, stack_err,
    output instr, btn
  );
endinterface

// File: rtl/cpu_param.sv
// Single-cycle parametrised teaching CPU. It fetches one 16-bit instruction per clock
// from an asynchronous ROM and executes it against eight registers, c/z flags,
// a return stack and a halt state. r5 samples the buttons and r6 drives the LEDs.
module cpu_param #(
  parameter int unsigned DW  = 4,
  parameter int unsigned PCW = 5,
  parameter int unsigned SD  = 4
) (
  input logic         clk,
  input logic         reset,
  cpu_param_if.master bus
);
  localparam int unsigned SpW  = $clog2(SD + 1);
  localparam int unsigned IdxW = (SD > 1) ? $clog2(SD) : 1;

  typedef enum logic [4:0] {
    OpNop, OpMov, OpAdd, OpSub, OpOr, OpAnd, OpXor, OpInc, OpNot,
    OpShr, OpShl, OpLdi, OpJmp, OpJc, OpJnc, OpJz, OpCall, OpRet, OpHalt
  } op_e;

  logic [4:0]     op;
  logic [2:0]     rd, rs;
  logic [7:0]     imm;
  logic [PCW-1:0] jmp_target;

  logic [DW-1:0]  regs_q [8];
  logic [DW-1:0]  regs_d [8];
  logic [PCW-1:0] pc_q, pc_d, pc_inc;
  logic           c_q, c_d, z_q, z_d;
  logic           halted_q, halted_d;
  logic           err_q, err_d;
  logic [SpW-1:0] sp_q, sp_d;
  logic [PCW-1:0] stack_q [SD];
  logic [PCW-1:0] stack_d [SD];

  logic [DW-1:0]   a_rd, a_r0, b_rs, res;
  logic [DW:0]     wide;
  logic            wr_en, set_z;
  logic [2:0]      wr_sel;
  logic [IdxW-1:0] push_idx, pop_idx;

  assign op         = bus.instr[15:11];
  assign rd         = bus.instr[10:8];
  assign rs         = bus.instr[2:0];
  assign imm        = bus.instr[7:0];
  assign jmp_target = imm[PCW-1:0];
  assign pc_inc     = pc_q + 1'b1;

  assign a_rd = regs_q[rd];
  assign a_r0 = regs_q[0];
  assign b_rs = regs_q[rs];

  // Push writes the slot at sp; pop reads the slot just below it.
  assign push_idx = IdxW'(sp_q);
  assign pop_idx  = IdxW'(sp_q - 1'b1);

  // Immediate bits beyond DW/PCW are ignored by design.
  logic unused_imm;
  assign unused_imm = ^imm;

  // Decode and execute the current instruction into next-state values.
  always_comb begin
    regs_d   = regs_q;
    pc_d     = pc_inc;
    c_d      = c_q;
    z_d      = z_q;
    sp_d     = sp_q;
    stack_d  = stack_q;
    halted_d = halted_q;
    err_d    = err_q;
    wide     = '0;
    res      = '0;
    wr_en    = 1'b0;
    wr_sel   = rd;
    set_z    = 1'b0;

    if (!halted_q) begin
      case (op_e'(op))
        OpMov: begin
          res   = b_rs;
          wr_en = 1'b1;
        end
        OpAdd: begin
          wide   = {1'b0, a_r0} + {1'b0, b_rs};
          res    = wide[DW-1:0];
          c_d    = wide[DW];
          wr_en  = 1'b1;
          wr_sel = 3'd0;
          set_z  = 1'b1;
        end
        OpSub: begin
          res    = a_r0 - b_rs;
          c_d    = (a_r0 < b_rs);
          wr_en  = 1'b1;
          wr_sel = 3'd0;
          set_z  = 1'b1;
        end
        OpOr, OpAnd, OpXor: begin
          if (op_e'(op) == OpOr)       res = a_r0 | b_rs;
          else if (op_e'(op) == OpAnd) res = a_r0 & b_rs;
          else                         res = a_r0 ^ b_rs;
          wr_en  = 1'b1;
          wr_sel = 3'd0;
          set_z  = 1'b1;
        end
        OpInc: begin
          wide  = {1'b0, a_rd} + 1'b1;
          res   = wide[DW-1:0];
          c_d   = wide[DW];
          wr_en = 1'b1;
          set_z = 1'b1;
        end
        OpNot: begin
          res   = ~a_rd;
          wr_en = 1'b1;
          set_z = 1'b1;
        end
        OpShr: begin
          res   = a_rd >> 1;
          c_d   = a_rd[0];
          wr_en = 1'b1;
          set_z = 1'b1;
        end
        OpShl: begin
          res   = a_rd << 1;
          c_d   = a_rd[DW-1];
          wr_en = 1'b1;
          set_z = 1'b1;
        end
        OpLdi: begin
          res   = imm[DW-1:0];
          wr_en = 1'b1;
        end
        OpJmp: pc_d = jmp_target;
        OpJc:  if (c_q)  pc_d = jmp_target;
        OpJnc: if (!c_q) pc_d = jmp_target;
        OpJz:  if (z_q)  pc_d = jmp_target;
        OpCall: begin
          // A full stack turns CALL into a flagged fall-through.
          if (sp_q == SpW'(SD)) begin
            err_d = 1'b1;
          end else begin
            stack_d[push_idx] = pc_inc;
            sp_d              = sp_q + 1'b1;
            pc_d              = jmp_target;
          end
        end
        OpRet: begin
          if (sp_q == '0) begin
            err_d = 1'b1;
          end else begin
            pc_d = stack_q[pop_idx];
            sp_d = sp_q - 1'b1;
          end
        end
        OpHalt: begin
          halted_d = 1'b1;
          pc_d     = pc_q;
        end
        default: ;
      endcase

      if (wr_en) regs_d[wr_sel] = res;
      if (set_z) z_d = (res == '0);
    end else begin
      pc_d = pc_q;
    end

    // r5 always tracks the buttons; instruction writes to it are lost.
    regs_d[5] = bus.btn;
  end

  // Architectural state, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      for (int i = 0; i < int'(SD); i++) stack_q[i] <= '0;
      pc_q     <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      sp_q     <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      stack_q  <= stack_d;
      pc_q     <= pc_d;
      c_q      <= c_d;
      z_q      <= z_d;
      sp_q     <= sp_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.led       = regs_q[6];
  assign bus.halted    = halted_q;
  assign bus.stack_err = err_q;
endmodule
